ro_puf_scheduler: RTL and testbench

//  Shares one Ring_Oscillator_PUF core between NUM_REQ requesters. Round-robin

---
 rtl/ro_puf_scheduler.sv | 150 +++++++++++++++
 tb/tb_ro_puf_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_scheduler.sv
// rtl/ro_puf_scheduler.sv - round-robin scheduler sharing one ring-oscillator PUF core
module ro_puf_scheduler #(
    parameter  int NUM_REQ     = 2,
    parameter  int CHALL_W     = 8,
    parameter  int RESP_W      = 8,
    parameter  int TIMEOUT_CYC = 1023,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*CHALL_W-1:0] req_chall,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [RESP_W-1:0]          resp_data,
    output logic [ID_W-1:0]            resp_id,
    output logic                       resp_err,
    output logic                       busy,
    output logic                       puf_rst,
    output logic                       puf_en,
    output logic [CHALL_W-1:0]         puf_chall,
    input  logic [RESP_W-1:0]          puf_response,
    input  logic                       puf_ready
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [TMR_W-1:0]   timer_q;
    logic               resp_valid_q;
    logic [RESP_W-1:0]  resp_data_q;
    logic [ID_W-1:0]    resp_id_q;
    logic               resp_err_q;
    logic               busy_q;
    logic               puf_rst_q;
    logic               puf_en_q;
    logic [CHALL_W-1:0] puf_chall_q;

    logic               found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [CHALL_W-1:0] grant_chall;

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        found        = 1'b0;
        grant_idx    = '0;
        idx          = 0;
        idx_w        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!found && req_valid[idx_w]) begin
                found     = 1'b1;
                grant_idx = idx_w;
            end
        end
        rr_ptr_d     = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
        grant_onehot = '0;
        grant_onehot[grant_idx] = 1'b1;
        grant_chall  = req_chall[int'(grant_idx)*CHALL_W +: CHALL_W];
        req_ready    = (state_q == S_IDLE && !rst && found) ? grant_onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            puf_rst_q    <= 1'b0;
            puf_en_q     <= 1'b0;
            puf_chall_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        puf_chall_q <= grant_chall;
                        resp_id_q   <= grant_idx;
                        rr_ptr_q    <= rr_ptr_d;
                        puf_rst_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ARM;
                    end
                end
                S_ARM: begin
                    puf_rst_q <= 1'b0;
                    puf_en_q  <= 1'b1;
                    timer_q   <= '0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    timer_q <= timer_q + TMR_W'(1);
                    // A ready arriving on the final timer cycle still counts as success.
                    if (puf_ready) begin
                        resp_data_q  <= puf_response;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        puf_en_q     <= 1'b0;
                        state_q      <= S_DONE;
                    end else if (timer_q == TMR_LAST) begin
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        puf_en_q     <= 1'b0;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign puf_rst    = puf_rst_q;
    assign puf_en     = puf_en_q;
    assign puf_chall  = puf_chall_q;

endmodule

// File: tb/tb_ro_puf_scheduler.sv
// tb/tb_ro_puf_scheduler.sv - directed self-checking bench for ro_puf_scheduler
module tb_ro_puf_scheduler;

    localparam int TO = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_chall = '0;
    logic [1:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [7:0]  resp_data;
    logic [0:0]  resp_id;
    logic        resp_err;
    logic        busy;
    logic        puf_rst;
    logic        puf_en;
    logic [7:0]  puf_chall;
    logic [7:0]  puf_response;
    logic        puf_ready;

    int chk_total = 0;
    int chk_pass  = 0;

    // Core model: ready after ready_delay enabled cycles, response = chall ^ key
    logic       core_on     = 1'b1;
    logic [7:0] key         = 8'hE8;
    logic [7:0] ready_delay = 8'd5;
    logic [7:0] en_cnt;

    always_ff @(posedge clk) begin
        if (!puf_en) en_cnt <= '0;
        else         en_cnt <= en_cnt + 8'd1;
    end
    assign puf_ready    = core_on && puf_en && (en_cnt == ready_delay);
    assign puf_response = puf_chall ^ key;

    always #5 clk = ~clk;

    ro_puf_scheduler #(.NUM_REQ(2), .CHALL_W(8), .RESP_W(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_chall(req_chall),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err), .busy(busy),
        .puf_rst(puf_rst), .puf_en(puf_en), .puf_chall(puf_chall),
        .puf_response(puf_response), .puf_ready(puf_ready)
    );

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output int n);
        n = 0;
        while (resp_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11;
        repeat (2) @(negedge clk);
        chk_total++;
        if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b exp 00", req_ready);
        else chk_pass++;
        chk_total++;
        if ({resp_valid, resp_err, busy, puf_rst, puf_en} !== 5'b0)
            $display("FAIL reset_flags: got %b exp 00000", {resp_valid, resp_err, busy, puf_rst, puf_en});
        else chk_pass++;
        chk_total++;
        if ({puf_chall, resp_data, resp_id} !== 17'h0)
            $display("FAIL reset_data: got %h exp 0", {puf_chall, resp_data, resp_id});
        else chk_pass++;
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        do_reset();
        core_on = 1'b1; key = 8'hE8; ready_delay = 8'd5;
        req_chall = 16'h00D4; req_valid = 2'b01;
        #1;
        chk_total++;
        if (req_ready !== 2'b01) $display("FAIL single_grant: got %b exp 01", req_ready);
        else chk_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        chk_total++;
        if ({puf_rst, puf_en, busy} !== 3'b101)
            $display("FAIL single_arm_flags: got %b exp 101", {puf_rst, puf_en, busy});
        else chk_pass++;
        chk_total++;
        if (puf_chall !== 8'hD4) $display("FAIL single_arm_chall: got %h exp d4", puf_chall);
        else chk_pass++;
        @(negedge clk);
        chk_total++;
        if ({puf_rst, puf_en} !== 2'b01) $display("FAIL single_run_flags: got %b exp 01", {puf_rst, puf_en});
        else chk_pass++;
        wait_resp(100, n);
        chk_total++;
        if (n !== 6) $display("FAIL single_latency: got %0d exp 6", n);
        else chk_pass++;
        chk_total++;
        if ({resp_data, resp_id, resp_err, puf_en} !== {8'h3C, 1'b0, 1'b0, 1'b0})
            $display("FAIL single_resp: got data=%h id=%b err=%b en=%b exp data=3c id=0 err=0 en=0",
                     resp_data, resp_id, resp_err, puf_en);
        else chk_pass++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk_total++;
        if ({resp_valid, busy} !== 2'b00) $display("FAIL single_release: got %b exp 00", {resp_valid, busy});
        else chk_pass++;
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_c [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
        do_reset();
        ready_delay = 8'd2;
        req_chall = 16'h2211; req_valid = 2'b11; resp_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (req_ready === 2'b00 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk_total++;
            if (req_ready !== exp_g[j]) $display("FAIL rr_grant%0d: got %b exp %b", j, req_ready, exp_g[j]);
            else chk_pass++;
            @(negedge clk);
            chk_total++;
            if (puf_chall !== exp_c[j]) $display("FAIL rr_chall%0d: got %h exp %h", j, puf_chall, exp_c[j]);
            else chk_pass++;
            wait_resp(100, n);
            chk_total++;
            if (resp_valid !== 1'b1 || resp_id !== 1'(j % 2))
                $display("FAIL rr_id%0d: got valid=%b id=%b exp valid=1 id=%0d", j, resp_valid, resp_id, j % 2);
            else chk_pass++;
            @(negedge clk);
            #1;
        end
        req_valid = 2'b00; resp_ready = 1'b0;
        repeat (12) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        core_on = 1'b0;
        req_chall = 16'h0077; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        wait_resp(1500, n);
        chk_total++;
        if (n !== TO) $display("FAIL timeout_cycles: got %0d exp %0d", n, TO);
        else chk_pass++;
        chk_total++;
        if ({resp_valid, resp_err, resp_data, busy} !== {1'b1, 1'b1, 8'h00, 1'b1})
            $display("FAIL timeout_resp: got valid=%b err=%b data=%h busy=%b exp 1 1 00 1",
                     resp_valid, resp_err, resp_data, busy);
        else chk_pass++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk_total++;
        if (busy !== 1'b0) $display("FAIL timeout_busy: got %b exp 0", busy);
        else chk_pass++;
        core_on = 1'b1;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        ready_delay = 8'd3;
        req_chall = 16'h5A00; req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        wait_resp(100, n);
        for (int k = 0; k < 10; k++) begin
            chk_total++;
            if ({resp_valid, resp_data, resp_id, resp_err, req_ready, puf_en} !==
                {1'b1, 8'hB2, 1'b1, 1'b0, 2'b00, 1'b0})
                $display("FAIL bp_hold%0d: got valid=%b data=%h id=%b err=%b rdy=%b en=%b exp 1 b2 1 0 00 0",
                         k, resp_valid, resp_data, resp_id, resp_err, req_ready, puf_en);
            else chk_pass++;
            @(negedge clk);
        end
        req_valid = 2'b00; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk_total++;
        if (resp_valid !== 1'b0) $display("FAIL bp_release: got %b exp 0", resp_valid);
        else chk_pass++;
    endtask

    task automatic test_reset_mid_run();
        int n;
        do_reset();
        ready_delay = 8'd20;
        req_chall = 16'h0033; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_total++;
        if ({resp_valid, resp_err, busy, puf_rst, puf_en} !== 5'b0)
            $display("FAIL midrst_flags: got %b exp 00000", {resp_valid, resp_err, busy, puf_rst, puf_en});
        else chk_pass++;
        chk_total++;
        if ({puf_chall, resp_data, resp_id} !== 17'h0)
            $display("FAIL midrst_data: got %h exp 0", {puf_chall, resp_data, resp_id});
        else chk_pass++;
        rst = 1'b0;
        ready_delay = 8'd2;
        req_valid = 2'b11;
        #1;
        chk_total++;
        if (req_ready !== 2'b01) $display("FAIL midrst_first_grant: got %b exp 01", req_ready);
        else chk_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        wait_resp(100, n);
        chk_total++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== (8'h33 ^ 8'hE8))
            $display("FAIL midrst_resp: got valid=%b id=%b data=%h exp 1 0 db", resp_valid, resp_id, resp_data);
        else chk_pass++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_sweep();
        int n;
        int got;
        do_reset();
        ready_delay = 8'd1; resp_ready = 1'b1; got = 0;
        for (int c = 0; c < 256; c++) begin
            req_chall = {8'(c), 8'h00}; req_valid = 2'b10;
            #1;
            n = 0;
            while (req_ready === 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk_total++;
            if (req_ready !== 2'b10) $display("FAIL sweep_grant%0d: got %b exp 10", c, req_ready);
            else chk_pass++;
            @(negedge clk);
            req_valid = 2'b00;
            chk_total++;
            if (puf_chall !== 8'(c)) $display("FAIL sweep_chall%0d: got %h exp %h", c, puf_chall, 8'(c));
            else chk_pass++;
            wait_resp(50, n);
            if (resp_valid === 1'b1) got++;
            chk_total++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== (8'(c) ^ 8'hE8))
                $display("FAIL sweep_resp%0d: got valid=%b id=%b data=%h exp 1 1 %h",
                         c, resp_valid, resp_id, resp_data, 8'(c) ^ 8'hE8);
            else chk_pass++;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        chk_total++;
        if (got !== 256) $display("FAIL sweep_count: got %0d exp 256", got);
        else chk_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
